// File: rtl/param_fifo.sv
// param_fifo: parameterised synchronous FIFO with almost flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is a registered read port.
module param_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     w_en,
  input  logic                     r_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF  = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE  = (AW+1)'(AE_THRESH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_w, do_r;
  assign count        = wr_ptr - rd_ptr;
  assign empty        = wr_ptr == rd_ptr;
  assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign almost_full  = count >= AF;
  assign almost_empty = count <= AE;
  assign do_w         = w_en & ~full;
  assign do_r         = r_en & ~empty;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= do_w ? wr_ptr + ONE : wr_ptr;
      rd_ptr    <= do_r ? rd_ptr + ONE : rd_ptr;
      // a fresh error outranks a concurrent clear
      overflow  <= (w_en & full) | (overflow & ~clr_err);
      underflow <= (r_en & empty) | (underflow & ~clr_err);
    end
  end
  always_ff @(posedge clk) begin
    if (do_w) mem[wr_ptr[AW-1:0]] <= data_in;
  end
`ifdef FIFO_FWFT_EN
  assign data_out = mem[rd_ptr[AW-1:0]];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_out <= '0;
    else if (do_r) data_out <= mem[rd_ptr[AW-1:0]];
  end
`endif
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed vector table plus a queue reference model for param_fifo.
module tb_param_fifo;
  logic clk = 1'b0, rst_n = 1'b0, w_en = 1'b0, r_en = 1'b0, clr_err = 1'b0;
  logic [7:0] data_in = '0, data_out;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int total = 0, bad = 0;
  logic [7:0] q [$];
  logic [7:0] exp_dout;
  logic exp_ov, exp_un;

  param_fifo dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en), .data_in(data_in),
    .clr_err(clr_err), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic w, r, c;
    logic [7:0] d;
    int cnt;
    logic f, e, af, ae, ov, un;
    logic [7:0] dq;
  } vec_t;
  vec_t vec [12];

  task automatic chk(input string n, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, req, $time);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    w_en = w; r_en = r; clr_err = c; data_in = d;
    @(posedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic check_model(input string n);
    chk({n, ".count"}, int'(count), q.size());
    chk({n, ".full"}, int'(full), int'(q.size() == 16));
    chk({n, ".empty"}, int'(empty), int'(q.size() == 0));
    chk({n, ".af"}, int'(almost_full), int'(q.size() >= 14));
    chk({n, ".ae"}, int'(almost_empty), int'(q.size() <= 2));
    chk({n, ".ovf"}, int'(overflow), int'(exp_ov));
    chk({n, ".unf"}, int'(underflow), int'(exp_un));
    chk({n, ".dout"}, int'(data_out), int'(exp_dout));
  endtask

  task automatic op(input string n, input logic w, input logic r, input logic c, input logic [7:0] d);
    logic wa, ra;
    wa = w && q.size() < 16;
    ra = r && q.size() > 0;
    step(w, r, c, d);
    if (ra) exp_dout = q.pop_front();
    if (wa) q.push_back(d);
    exp_ov = (w && !wa) || (exp_ov && !c);
    exp_un = (r && !ra) || (exp_un && !c);
    check_model(n);
  endtask

  initial begin
    vec[0]  = '{1'b1, 1'b0, 1'b0, 8'hA1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vec[1]  = '{1'b1, 1'b0, 1'b0, 8'hB2, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vec[2]  = '{1'b1, 1'b0, 1'b0, 8'hC3, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vec[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA1};
    vec[4]  = '{1'b1, 1'b1, 1'b0, 8'hD4, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB2};
    vec[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3};
    vec[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hD4};
    vec[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hD4};
    vec[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hD4};
    vec[9]  = '{1'b1, 1'b1, 1'b0, 8'hE5, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hD4};
    vec[10] = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hE5};
    vec[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hE5};

    #1;
    chk("rst.count", int'(count), 0);
    chk("rst.empty", int'(empty), 1);
    chk("rst.full", int'(full), 0);
    chk("rst.ae", int'(almost_empty), 1);
    chk("rst.af", int'(almost_full), 0);
    chk("rst.ovf", int'(overflow), 0);
    chk("rst.unf", int'(underflow), 0);
    chk("rst.dout", int'(data_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(vec[i].w, vec[i].r, vec[i].c, vec[i].d);
      chk($sformatf("vec%0d.count", i), int'(count), vec[i].cnt);
      chk($sformatf("vec%0d.full", i), int'(full), int'(vec[i].f));
      chk($sformatf("vec%0d.empty", i), int'(empty), int'(vec[i].e));
      chk($sformatf("vec%0d.af", i), int'(almost_full), int'(vec[i].af));
      chk($sformatf("vec%0d.ae", i), int'(almost_empty), int'(vec[i].ae));
      chk($sformatf("vec%0d.ovf", i), int'(overflow), int'(vec[i].ov));
      chk($sformatf("vec%0d.unf", i), int'(underflow), int'(vec[i].un));
      chk($sformatf("vec%0d.dout", i), int'(data_out), int'(vec[i].dq));
    end

    exp_dout = 8'hE5; exp_ov = 1'b0; exp_un = 1'b0;
    for (int i = 0; i < 16; i++) op("fill", 1'b1, 1'b0, 1'b0, 8'(i));
    op("wr17", 1'b1, 1'b0, 1'b0, 8'h99);
    op("clr", 1'b0, 1'b0, 1'b1, 8'h00);
    op("clr_vs_ovf", 1'b1, 1'b0, 1'b1, 8'h98);
    op("clr2", 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) op("drain", 1'b0, 1'b1, 1'b0, 8'h00);
    op("rd17", 1'b0, 1'b1, 1'b0, 8'h00);
    op("clr3", 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) op("half", 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 40; i++) op("simul", 1'b1, 1'b1, 1'b0, 8'(8'h50 + i));
    for (int i = 0; i < 8; i++) op("refill", 1'b1, 1'b0, 1'b0, 8'(8'hA0 + i));
    op("both_full", 1'b1, 1'b1, 1'b0, 8'hEE);
    op("clr4", 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) op("to5", 1'b0, 1'b1, 1'b0, 8'h00);

    #2 rst_n = 1'b0;
    #1;
    chk("arst.count", int'(count), 0);
    chk("arst.empty", int'(empty), 1);
    chk("arst.full", int'(full), 0);
    chk("arst.ae", int'(almost_empty), 1);
    chk("arst.af", int'(almost_full), 0);
    chk("arst.dout", int'(data_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    exp_dout = 8'h00; exp_ov = 1'b0; exp_un = 1'b0;
    op("post_rst_wr", 1'b1, 1'b0, 1'b0, 8'h77);
    op("post_rst_rd", 1'b0, 1'b1, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
